// File: rtl/redund_pkg.sv
// Shared sizing, operand vector type and sequencer states for the
// carry-save to canonical radix-2^16 resolve path.
package redund_pkg;

    localparam int unsigned NUM_DIGITS = 130;
    localparam int unsigned DIGIT_W    = 19;
    localparam int unsigned RADIX_W    = 16;
    localparam int unsigned IDX_W      = 8;
    localparam int unsigned CARRY_W    = 5;

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] redund_vec_t;

    typedef enum logic {
        IDLE,
        RUN
    } rr_state_t;

endpackage

// File: rtl/digit_resolve.sv
// One carry-save column plus incoming carry folded into a canonical digit
// and the carry passed to the next column up.
module digit_resolve #(
    parameter int unsigned DIGIT_W = redund_pkg::DIGIT_W,
    parameter int unsigned RADIX_W = redund_pkg::RADIX_W,
    parameter int unsigned CARRY_W = redund_pkg::CARRY_W
) (
    input  logic [DIGIT_W-1:0] i_c,
    input  logic [DIGIT_W-1:0] i_s,
    input  logic [CARRY_W-1:0] i_carry_in,
    output logic [RADIX_W-1:0] o_digit,
    output logic [CARRY_W-1:0] o_carry_out
);

    // Two extra bits hold C+S+carry without overflow.
    logic [DIGIT_W+1:0] w_sum;

    always_comb begin
        w_sum = {2'b00, i_c} + {2'b00, i_s} + (DIGIT_W+2)'(i_carry_in);
    end

    assign o_digit     = w_sum[RADIX_W-1:0];
    assign o_carry_out = CARRY_W'(w_sum >> RADIX_W);

endmodule

// File: rtl/redundant_resolve_seq.sv
// Captures one carry-save operand and streams its canonical radix-2^16
// digits LSB-first with a full carry chain, one digit per accepted beat.
module redundant_resolve_seq #(
    parameter int unsigned NUM_DIGITS = redund_pkg::NUM_DIGITS,
    parameter int unsigned DIGIT_W    = redund_pkg::DIGIT_W,
    parameter int unsigned RADIX_W    = redund_pkg::RADIX_W,
    parameter int unsigned IDX_W      = redund_pkg::IDX_W,
    parameter int unsigned CARRY_W    = redund_pkg::CARRY_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  in_c,
    input  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  in_s,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [RADIX_W-1:0]                  out_digit,
    output logic [IDX_W-1:0]                    out_index,
    output logic                                out_last,
    output logic [CARRY_W-1:0]                  carry_out,
    output logic                                busy
);

    import redund_pkg::*;

    rr_state_t                          r_state;
    rr_state_t                          w_state_next;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_c;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_s;
    logic [IDX_W-1:0]                   r_idx;
    logic [CARRY_W-1:0]                 r_carry;

    logic [DIGIT_W-1:0]                 w_c_sel;
    logic [DIGIT_W-1:0]                 w_s_sel;
    logic [RADIX_W-1:0]                 w_digit;
    logic [CARRY_W-1:0]                 w_carry_next;
    logic                               w_is_last;
    logic                               w_capture;
    logic                               w_beat;

    // Explicit compare-mux keeps the column select width-clean for any NUM_DIGITS.
    always_comb begin
        w_c_sel = '0;
        w_s_sel = '0;
        for (int unsigned m = 0; m < NUM_DIGITS; m++) begin
            if (r_idx == IDX_W'(m)) begin
                w_c_sel = r_c[m];
                w_s_sel = r_s[m];
            end
        end
    end

    assign w_is_last = (r_idx == IDX_W'(NUM_DIGITS - 1));

    digit_resolve #(
        .DIGIT_W (DIGIT_W),
        .RADIX_W (RADIX_W),
        .CARRY_W (CARRY_W)
    ) u_digit_resolve (
        .i_c         (w_c_sel),
        .i_s         (w_s_sel),
        .i_carry_in  (r_carry),
        .o_digit     (w_digit),
        .o_carry_out (w_carry_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_beat       = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_digit    = '0;
        out_index    = '0;
        out_last     = 1'b0;
        carry_out    = '0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready  = 1'b1;
                w_capture = in_valid;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_digit = w_digit;
                out_index = r_idx;
                out_last  = w_is_last;
                if (w_is_last) begin
                    carry_out = w_carry_next;
                end
                w_beat = out_ready;
                if (out_ready && w_is_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand banks carry no reset; they are only read while RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_c     <= in_c;
                r_s     <= in_s;
                r_idx   <= '0;
                r_carry <= '0;
            end else if (w_beat) begin
                r_carry <= w_carry_next;
                r_idx   <= w_is_last ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_redundant_resolve_seq.sv
// Self-checking bench: table-driven operands, directed stall/poke/reset
// sequences and random operands against a bignum reference model.
module tb_redundant_resolve_seq;

    localparam int ND  = 130;
    localparam int ND4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [ND-1:0][18:0]   in_c;
    logic [ND-1:0][18:0]   in_s;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_digit;
    logic [7:0]            out_index;
    logic                  out_last;
    logic [4:0]            carry_out;
    logic                  busy;

    logic                  in_valid4;
    logic                  in_ready4;
    logic [ND4-1:0][18:0]  in_c4;
    logic [ND4-1:0][18:0]  in_s4;
    logic                  out_valid4;
    logic                  out_ready4;
    logic [15:0]           out_digit4;
    logic [7:0]            out_index4;
    logic                  out_last4;
    logic [4:0]            carry_out4;
    logic                  busy4;

    redundant_resolve_seq u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_c      (in_c),
        .in_s      (in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_index (out_index),
        .out_last  (out_last),
        .carry_out (carry_out),
        .busy      (busy)
    );

    redundant_resolve_seq #(.NUM_DIGITS(ND4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_c      (in_c4),
        .in_s      (in_s4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_digit (out_digit4),
        .out_index (out_index4),
        .out_last  (out_last4),
        .carry_out (carry_out4),
        .busy      (busy4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [ND-1:0][18:0] op_c, op_s, op2_c, op2_s;
    int                  exp_d [ND];
    int                  exp_cout;
    logic [15:0]         got_d [ND];
    logic [4:0]          got_cout;

    typedef struct {
        string       nm;
        logic [18:0] c_lo, s_lo, c_hi, s_hi;
        logic [15:0] e_d0, e_d1, e_dhi;
        logic [4:0]  e_cout;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Adds every column value at its weight into a limb accumulator.
    function automatic void model();
        longint acc [ND+2];
        longint t;
        int     k;
        foreach (acc[i]) acc[i] = 0;
        for (int m = 0; m < ND; m++) begin
            for (int p = 0; p < 2; p++) begin
                t = (p == 0) ? longint'(op_c[m]) : longint'(op_s[m]);
                k = m;
                while (t != 0 && k < ND + 2) begin
                    t      = t + acc[k];
                    acc[k] = t % 65536;
                    t      = t / 65536;
                    k++;
                end
            end
        end
        for (int i = 0; i < ND; i++) exp_d[i] = int'(acc[i]);
        exp_cout = int'(acc[ND] + acc[ND+1] * 65536);
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic run_op(input int rdy_pct, input int stall_at, input int poke_at, input int reset_at);
        int beat, cyc, stalls;
        bit poked;
        model();
        in_c      = op_c;
        in_s      = op_s;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        in_valid = 1'b0;
        beat = 0; cyc = 0; stalls = 0; poked = 0;
        while (beat < ND && cyc < 1000) begin
            if (beat == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_out_index", out_index, 0);
                return;
            end
            if (beat == poke_at && !poked) begin
                poked    = 1;
                in_c     = op2_c;
                in_s     = op2_s;
                in_valid = 1'b1;
            end
            if (beat == stall_at && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = ($urandom_range(99) < rdy_pct);
            end
            chk($sformatf("out_valid[%0d]", beat), out_valid, 1);
            chk($sformatf("busy[%0d]", beat), busy, 1);
            chk($sformatf("out_index[%0d]", beat), out_index, beat);
            chk($sformatf("out_last[%0d]", beat), out_last, (beat == ND - 1));
            chk($sformatf("digit[%0d]", beat), out_digit, exp_d[beat]);
            if (poked) chk($sformatf("run_in_ready[%0d]", beat), in_ready, 0);
            if (out_ready) begin
                got_d[beat] = out_digit;
                if (beat == ND - 1) begin
                    got_cout = carry_out;
                    chk("carry_out", carry_out, exp_cout);
                end
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("beats_done", beat, ND);
        chk("end_out_valid", out_valid, 0);
        chk("end_in_ready", in_ready, 1);
        chk("end_busy", busy, 0);
        chk("end_out_last", out_last, 0);
        if (rdy_pct == 100 && stall_at < 0) chk("drain_cycles", cyc, ND);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e4 [4];
        int beat, cyc;

        tbl[0] = '{"zero",     19'h0,     19'h0,     19'h0,     19'h0,     16'h0000, 16'h0000, 16'h0000, 5'h00};
        tbl[1] = '{"carry1",   19'h0FFFF, 19'h00001, 19'h0,     19'h0,     16'h0000, 16'h0001, 16'h0000, 5'h00};
        tbl[2] = '{"lo_max",   19'h7FFFF, 19'h7FFFF, 19'h0,     19'h0,     16'hFFFE, 16'h000F, 16'h0000, 5'h00};
        tbl[3] = '{"hi_max",   19'h0,     19'h0,     19'h7FFFF, 19'h7FFFF, 16'h0000, 16'h0000, 16'hFFFE, 5'h0F};
        tbl[4] = '{"lo_2p16",  19'h10000, 19'h0,     19'h0,     19'h0,     16'h0000, 16'h0001, 16'h0000, 5'h00};
        tbl[5] = '{"hi_mixed", 19'h0,     19'h0,     19'h12345, 19'h0ABCD, 16'h0000, 16'h0000, 16'hCF12, 5'h01};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_c = '0; in_s = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; in_c4 = '0; in_s4 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_digit", out_digit, 0);
        chk("rst_carry_out", carry_out, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            op_c = '0; op_s = '0;
            op_c[0] = tbl[v].c_lo;    op_s[0] = tbl[v].s_lo;
            op_c[ND-1] = tbl[v].c_hi; op_s[ND-1] = tbl[v].s_hi;
            run_op(100, -1, -1, -1);
            chk({tbl[v].nm, "_d0"},   got_d[0],    tbl[v].e_d0);
            chk({tbl[v].nm, "_d1"},   got_d[1],    tbl[v].e_d1);
            chk({tbl[v].nm, "_dhi"},  got_d[ND-1], tbl[v].e_dhi);
            chk({tbl[v].nm, "_cout"}, got_cout,    tbl[v].e_cout);
        end

        // Stall for three cycles on index 5 with C[m]=m.
        for (int m = 0; m < ND; m++) begin
            op_c[m] = 19'(m);
            op_s[m] = '0;
        end
        run_op(100, 5, -1, -1);
        chk("stall_d5", got_d[5], 16'h0005);
        chk("stall_d6", got_d[6], 16'h0006);

        // Second operand offered mid-stream; must wait for the drain.
        for (int m = 0; m < ND; m++) begin
            op_c[m]  = 19'($urandom_range(0, 19'h7FFFF));
            op_s[m]  = 19'($urandom_range(0, 19'h7FFFF));
            op2_c[m] = 19'($urandom_range(0, 19'h7FFFF));
            op2_s[m] = 19'($urandom_range(0, 19'h7FFFF));
        end
        run_op(100, -1, 40, -1);
        op_c = op2_c; op_s = op2_s;
        run_op(80, -1, -1, -1);

        // Reset at index 60, then a carry-sensitive operand.
        run_op(100, -1, -1, 60);
        op_c = '0; op_s = '0;
        op_c[0] = 19'h0FFFF; op_s[0] = 19'h00001;
        run_op(100, -1, -1, -1);
        chk("post_rst_d0", got_d[0], 16'h0000);
        chk("post_rst_d1", got_d[1], 16'h0001);

        // Reset and in_valid together: nothing captured.
        reset = 1'b1; in_valid = 1'b1; in_c = op2_c; in_s = op2_s;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        chk("rst_vs_valid_busy", busy, 0);
        chk("rst_vs_valid_out_valid", out_valid, 0);
        @(negedge clk);
        chk("rst_vs_valid_busy2", busy, 0);
        chk("rst_vs_valid_in_ready", in_ready, 1);

        for (int r = 0; r < 5; r++) begin
            for (int m = 0; m < ND; m++) begin
                op_c[m] = (r == 4) ? 19'h7FFFF : 19'($urandom_range(0, 19'h7FFFF));
                op_s[m] = (r == 4) ? 19'h7FFFF : 19'($urandom_range(0, 19'h7FFFF));
            end
            run_op(30 + 15 * r, -1, -1, -1);
        end

        // Four-digit instance, all columns at maximum.
        e4[0] = 16'hFFFE; e4[1] = 16'h000D; e4[2] = 16'h000E; e4[3] = 16'h000E;
        for (int m = 0; m < ND4; m++) begin
            in_c4[m] = 19'h7FFFF;
            in_s4[m] = 19'h7FFFF;
        end
        in_valid4 = 1'b1; out_ready4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        beat = 0; cyc = 0;
        while (beat < ND4 && cyc < 20) begin
            chk($sformatf("n4_valid[%0d]", beat), out_valid4, 1);
            chk($sformatf("n4_index[%0d]", beat), out_index4, beat);
            chk($sformatf("n4_digit[%0d]", beat), out_digit4, e4[beat]);
            chk($sformatf("n4_last[%0d]", beat), out_last4, (beat == ND4 - 1));
            if (beat == ND4 - 1) chk("n4_cout", carry_out4, 5'h10);
            beat++;
            @(negedge clk);
            cyc++;
        end
        chk("n4_beats", beat, ND4);
        chk("n4_in_ready", in_ready4, 1);
        chk("n4_busy", busy4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
